// File: rtl/seg7_scan_driver.sv
// Scans a packed 8-character display bus onto an 8-digit common-anode seven-segment panel.
// Each digit slot starts with a blanking interval. The bus is snapshotted once per frame.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] display_i,
  input  logic [7:0]  dp_i,
  input  logic        enable_i,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        frame_sync_o
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state_q, next_state;
  logic [SW-1:0] slot_q, next_slot;
  logic [2:0]    digit_q, next_digit;
  logic [63:0]   frame_q, src;
  logic          run_q, snap_now;
  logic [7:0]    cur_char;
  logic [6:0]    glyph;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
      4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h0E;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [7:0] c);
    logic [6:0] r;
    if (c < 8'h10)                                        r = hex7(c[3:0]);
    else if (c >= 8'h30 && c <= 8'h39)                    r = hex7(c[3:0]);
    else if ((c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66))                  r = hex7(c[3:0] + 4'd9);
    else if (c == 8'h20)                                  r = 7'h7F;
    else if (c == 8'h2D)                                  r = 7'h3F;
    else if (c == 8'h5F)                                  r = 7'h77;
    else                                                  r = 7'h36;
    return r;
  endfunction

  // Outputs are registered from the next (digit, slot) so they line up with the counters.
  // run_q makes the first edge after reset land on digit 0 slot 0 rather than advancing.
  always_comb begin
    next_slot  = slot_q;
    next_digit = digit_q;
    if (!run_q) begin
      next_slot  = '0;
      next_digit = '0;
    end else if (slot_q == SW'(SCAN_DIV - 1)) begin
      next_slot  = '0;
      next_digit = digit_q + 3'd1;
    end else begin
      next_slot = slot_q + SW'(1);
    end

    next_state = state_q;
    case (state_q)
      BLANK:   if (next_slot == SW'(BLANK_CYC)) next_state = DRIVE;
      DRIVE:   if (next_slot == '0)             next_state = BLANK;
      default: next_state = BLANK;
    endcase

    // Bypass the snapshot register on the cycle it loads so a 1-cycle blank still sees new data.
    snap_now = run_q && (slot_q == '0) && (digit_q == '0);
    src      = snap_now ? display_i : frame_q;
    cur_char = src[{next_digit, 3'b000} +: 8];
    glyph    = decode(cur_char);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q        <= 1'b0;
      slot_q       <= '0;
      digit_q      <= '0;
      state_q      <= BLANK;
      frame_q      <= '0;
      an_o         <= 8'hFF;
      seg_o        <= 8'hFF;
      frame_sync_o <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      slot_q       <= next_slot;
      digit_q      <= next_digit;
      state_q      <= next_state;
      if (snap_now) frame_q <= display_i;
      frame_sync_o <= (next_slot == '0) && (next_digit == '0);
      if (next_state == DRIVE && enable_i) begin
        an_o  <= ~(8'b1 << next_digit);
        seg_o <= {~dp_i[next_digit], glyph};
      end else begin
        an_o  <= 8'hFF;
        seg_o <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2.
// cyc n is sampled 1 ns after the edge that starts cycle n; inputs set there act at the next edge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] display_i = '0;
  logic [7:0]  dp_i = '0;
  logic        enable_i = 1'b1;
  logic [7:0]  an_o, seg_o;
  logic        frame_sync_o;

  int tests_run = 0;
  int fails = 0;
  int cyc = -1;

  localparam logic [63:0] DIGITS = 64'h3736353433323130;
  localparam logic [63:0] DASHES = 64'h2D2D2D2D2D2D2D2D;
  localparam logic [63:0] HEXF   = 64'h0F0F0F0F0F0F0F0F;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rstn(rstn), .display_i(display_i), .dp_i(dp_i),
    .enable_i(enable_i), .an_o(an_o), .seg_o(seg_o), .frame_sync_o(frame_sync_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkPanel(input string tag, input logic [7:0] exp_an, input logic [7:0] exp_seg);
    checkOutput({tag, "_an"}, {56'd0, an_o}, {56'd0, exp_an});
    checkOutput({tag, "_seg"}, {56'd0, seg_o}, {56'd0, exp_seg});
  endtask

  task automatic applyStimulus(input logic [63:0] disp, input logic [7:0] dp, input logic en);
    display_i = disp;
    dp_i      = dp;
    enable_i  = en;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset for n edges, checking the reset state, then release so the next edge is cycle 0.
  task automatic doReset(input int n);
    rstn = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkPanel("reset", 8'hFF, 8'hFF);
      checkOutput("reset_sync", {63'd0, frame_sync_o}, 64'd0);
    end
    rstn = 1'b1;
    cyc  = -1;
  endtask

  initial begin
    // 1: hex F on every digit, digit 0 timing
    applyStimulus(HEXF, 8'h00, 1'b1);
    doReset(3);
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      checkOutput("t1_sync", {63'd0, frame_sync_o}, (cyc == 0) ? 64'd1 : 64'd0);
      if (cyc < 2) checkPanel("t1_blank", 8'hFF, 8'hFF);
      else         checkPanel("t1_drive", 8'hFE, 8'h8E);
    end

    // 2: ASCII digits across a whole frame
    applyStimulus(DIGITS, 8'h00, 1'b1);
    doReset(1);
    for (int i = 0; i < 65; i++) begin
      nextCycle();
      if (cyc inside {[2:7]})   checkPanel("t2_d0", 8'hFE, 8'hC0);
      if (cyc inside {[8:9]})   checkPanel("t2_d1blank", 8'hFF, 8'hFF);
      if (cyc inside {[10:15]}) checkPanel("t2_d1", 8'hFD, 8'hF9);
      if (cyc inside {[58:63]}) checkPanel("t2_d7", 8'h7F, 8'hF8);
      if (cyc == 8)  checkOutput("t2_nosync", {63'd0, frame_sync_o}, 64'd0);
      if (cyc == 64) begin
        checkOutput("t2_sync64", {63'd0, frame_sync_o}, 64'd1);
        checkPanel("t2_c64", 8'hFF, 8'hFF);
      end
    end

    // 3: bus change mid-frame stays hidden until the next snapshot
    applyStimulus(DIGITS, 8'h00, 1'b1);
    doReset(1);
    for (int i = 0; i < 72; i++) begin
      nextCycle();
      if (cyc == 19) display_i = DASHES;
      if (cyc inside {[18:23]}) checkPanel("t3_d2", 8'hFB, 8'hA4);
      if (cyc inside {[58:63]}) checkPanel("t3_d7", 8'h7F, 8'hF8);
      if (cyc inside {[66:71]}) checkPanel("t3_new", 8'hFE, 8'hBF);
    end

    // 4: unknown glyph with decimal point, then a driven blank
    applyStimulus(64'h0000_0000_0000_2040, 8'h01, 1'b1);
    doReset(1);
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      if (cyc inside {[2:7]})   checkPanel("t4_unk", 8'hFE, 8'h36);
      if (cyc inside {[10:15]}) checkPanel("t4_spc", 8'hFD, 8'hFF);
    end

    // 5: panel dark over cycles 4-12 while timing runs on
    applyStimulus(DIGITS, 8'h00, 1'b1);
    doReset(1);
    for (int i = 0; i < 65; i++) begin
      nextCycle();
      if (cyc == 3) begin
        checkPanel("t5_pre", 8'hFE, 8'hC0);
        enable_i = 1'b0;
      end
      if (cyc inside {[4:12]}) checkPanel("t5_dark", 8'hFF, 8'hFF);
      if (cyc == 12) enable_i = 1'b1;
      if (cyc == 13) checkPanel("t5_resume", 8'hFD, 8'hF9);
      if (cyc == 64) checkOutput("t5_sync64", {63'd0, frame_sync_o}, 64'd1);
    end

    // 6: reset mid-frame, restart with a fresh snapshot
    applyStimulus(HEXF, 8'h00, 1'b1);
    doReset(1);
    for (int i = 0; i < 39; i++) begin
      nextCycle();
      if (cyc == 37) begin
        checkPanel("t6_pre", 8'hEF, 8'h8E);
        rstn = 1'b0;
      end
      if (cyc == 38) begin
        checkPanel("t6_rst", 8'hFF, 8'hFF);
        checkOutput("t6_rst_sync", {63'd0, frame_sync_o}, 64'd0);
        rstn = 1'b1;
        display_i = DIGITS;
      end
    end
    cyc = -1;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      if (cyc == 0) begin
        checkOutput("t6_sync", {63'd0, frame_sync_o}, 64'd1);
        checkPanel("t6_c0", 8'hFF, 8'hFF);
      end
      if (cyc inside {[2:7]}) checkPanel("t6_fresh", 8'hFE, 8'hC0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
